regfile_wr_arbiter: RTL and testbench

- Owns the single write port of the 100-entry x 64-bit register file.
- After reset, sequences a full register-file initialisation, one entry per cycle: reg1 = 64'hFFFF, all others 0.
- After that, shares the write port between NUM_REQ writeback requesters (ALU, load unit, mul/div), using round-robin arbitration and a valid/ready handshake.
- Blocks writes to protected registers 0 and 1, and to out-of-range addresses.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/regfile_wr_arbiter.sv | 125 ++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, state encoding and address-protection helper for the
// register-file write-port arbiter.
package regfile_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned NUM_REGS  = 100;
  localparam logic [63:0] REG1_INIT = 64'hFFFF;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_ONES = 1;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Registers 0 and 1 hold fixed values; anything past the implemented range is dropped.
  function automatic logic is_writable(input int unsigned addr, input int unsigned nregs);
    return (addr != REG_ZERO) && (addr != REG_ONES) && (addr < nregs);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after
// ptr (wrapping) wins. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (en) begin
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
        idx = (32'(ptr) + off) % NUM_REQ;
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = IDX_W'(idx);
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Owns the register-file write port: runs the post-reset initialisation sweep,
// then shares the port round-robin between writeback requesters.
module regfile_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned ADDR_W    = regfile_pkg::ADDR_W,
  parameter int unsigned DATA_W    = regfile_pkg::DATA_W,
  parameter int unsigned NUM_REGS  = regfile_pkg::NUM_REGS,
  parameter logic [63:0] REG1_INIT = regfile_pkg::REG1_INIT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      soft_init,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic                      init_done,
  output logic                      wr_err
);

  import regfile_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  // Handshake: requester i transfers on a clk edge where req_valid[i] & req_ready[i];
  // ready is one-hot, combinational, and never depends on the same requester's data.
  state_t              state, state_nx;
  logic [ADDR_W-1:0]   init_cnt, init_cnt_nx;
  logic [IDX_W-1:0]    rr_ptr, rr_ptr_nx;
  logic                we_nx, done_nx, err_nx;
  logic [ADDR_W-1:0]   waddr_nx;
  logic [DATA_W-1:0]   wdata_nx;

  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    gidx;
  logic                arb_en, xfer;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  assign arb_en    = (state == S_RUN) && !soft_init;
  assign req_ready = grant;
  assign xfer      = |grant;
  assign sel_addr  = req_addr[gidx*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[gidx*DATA_W +: DATA_W];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (gidx)
  );

  always_comb begin
    state_nx    = state;
    init_cnt_nx = init_cnt;
    rr_ptr_nx   = rr_ptr;
    we_nx       = 1'b0;
    waddr_nx    = rf_waddr;
    wdata_nx    = rf_wdata;
    done_nx     = init_done;
    err_nx      = 1'b0;
    case (state)
      S_INIT: begin
        we_nx    = 1'b1;
        waddr_nx = init_cnt;
        wdata_nx = (32'(init_cnt) == REG_ONES) ? DATA_W'(REG1_INIT) : '0;
        if (32'(init_cnt) == NUM_REGS - 1) begin
          state_nx    = S_RUN;
          done_nx     = 1'b1;
          init_cnt_nx = '0;
        end else begin
          init_cnt_nx = init_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (soft_init) begin
          state_nx    = S_INIT;
          done_nx     = 1'b0;
          init_cnt_nx = '0;
        end else if (xfer) begin
          rr_ptr_nx = (32'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
          // Protected or out-of-range writes are still consumed so the requester never stalls.
          if (is_writable(32'(sel_addr), NUM_REGS)) begin
            we_nx    = 1'b1;
            waddr_nx = sel_addr;
            wdata_nx = sel_data;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      default: state_nx = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_INIT;
      init_cnt  <= '0;
      rr_ptr    <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      init_done <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      state     <= state_nx;
      init_cnt  <= init_cnt_nx;
      rr_ptr    <= rr_ptr_nx;
      rf_we     <= we_nx;
      rf_waddr  <= waddr_nx;
      rf_wdata  <= wdata_nx;
      init_done <= done_nx;
      wr_err    <= err_nx;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomised bench for regfile_wr_arbiter: a behavioural model predicts every
// output each cycle, and directed phases pin the model with literal values.
module tb_regfile_wr_arbiter;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 64;
  localparam int NR = 100;

  logic              clk;
  logic              reset;
  logic              soft_init;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_wdata;
  logic              init_done;
  logic              wr_err;

  int checks   = 0;
  int failures = 0;

  regfile_wr_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .soft_init (soft_init),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .init_done (init_done),
    .wr_err    (wr_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: pending init addresses in a queue, pointer as an integer
  logic [AW-1:0] exp_q[$];
  bit            m_run;
  int            m_ptr;
  logic          e_we, e_done, e_err;
  logic [AW-1:0] e_waddr;
  logic [DW-1:0] e_wdata;

  function automatic int model_grant();
    if (!m_run || soft_init) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic refill();
    exp_q.delete();
    for (int a = 0; a < NR; a++) exp_q.push_back(AW'(a));
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      refill();
      m_run = 0; m_ptr = 0;
      e_we = 0; e_waddr = '0; e_wdata = '0; e_done = 0; e_err = 0;
    end else if (!m_run) begin
      logic [AW-1:0] a;
      a       = exp_q.pop_front();
      e_we    = 1'b1;
      e_waddr = a;
      e_wdata = (a == 1) ? 64'hFFFF : 64'h0;
      e_err   = 1'b0;
      if (exp_q.size() == 0) begin
        m_run  = 1;
        e_done = 1'b1;
      end
    end else begin
      int g;
      int unsigned ad;
      g = model_grant();
      e_we  = 1'b0;
      e_err = 1'b0;
      if (soft_init) begin
        refill();
        m_run  = 0;
        e_done = 1'b0;
      end else if (g >= 0) begin
        m_ptr = (g + 1) % N;
        ad    = 32'(req_addr[g*AW +: AW]);
        if (ad >= 2 && ad < NR) begin
          e_we    = 1'b1;
          e_waddr = req_addr[g*AW +: AW];
          e_wdata = req_data[g*DW +: DW];
        end else begin
          e_err = 1'b1;
        end
      end
    end
  end

  // single compare process, mid-cycle
  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    g  = model_grant();
    er = (g < 0) ? '0 : N'(1 << g);
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("rf_we", 64'(rf_we), 64'(e_we));
    chk("rf_waddr", 64'(rf_waddr), 64'(e_waddr));
    chk("rf_wdata", rf_wdata, e_wdata);
    chk("init_done", 64'(init_done), 64'(e_done));
    chk("wr_err", 64'(wr_err), 64'(e_err));
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]        = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic all_valid_in_range();
    for (int i = 0; i < N; i++)
      set_req(i, 1'b1, AW'($urandom_range(2, NR - 1)), {$urandom, $urandom});
  endtask

  task automatic idle();
    req_valid = '0;
  endtask

  // counts edges until init_done rises, checking the sweep against literals
  task automatic run_init(input string tag);
    int cyc, n_we;
    logic [AW-1:0] first;
    logic [DW-1:0] d1;
    cyc = 0; n_we = 0; first = '1; d1 = '0;
    for (int c = 1; c <= 150; c++) begin
      tick();
      if (c == 1) first = rf_waddr;
      if (rf_we) n_we++;
      if (rf_we && rf_waddr == 1) d1 = rf_wdata;
      if (init_done) begin
        cyc = c;
        break;
      end
    end
    chk({tag, "_init_cycles"}, 64'(cyc), 64'd100);
    chk({tag, "_init_writes"}, 64'(n_we), 64'd100);
    chk({tag, "_init_first_addr"}, 64'(first), 64'd0);
    chk({tag, "_init_reg1_data"}, d1, 64'hFFFF);
  endtask

  function automatic int ready_idx();
    for (int i = 0; i < N; i++) if (req_ready[i]) return i;
    return -1;
  endfunction

  initial begin
    int exp_rot[6];
    exp_rot = '{0, 1, 2, 0, 1, 2};
    reset = 1'b1; soft_init = 1'b0;
    req_valid = '0; req_addr = '0; req_data = '0;
    tick(); tick();
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_wr_err", 64'(wr_err), 64'd0);
    reset = 1'b0;

    // requests held during init must see no grant
    all_valid_in_range();
    run_init("first");

    // rotation with everyone valid
    for (int k = 0; k < 6; k++) begin
      chk("rotation_grant", 64'(ready_idx()), 64'(exp_rot[k]));
      all_valid_in_range();
      #1;
      tick();
    end

    // directed write through requester 1
    idle();
    set_req(1, 1'b1, 8'd5, 64'hDEAD_BEEF);
    #1;
    chk("dir_ready", 64'(req_ready), 64'b010);
    tick();
    chk("dir_we", 64'(rf_we), 64'd1);
    chk("dir_waddr", 64'(rf_waddr), 64'd5);
    chk("dir_wdata", rf_wdata, 64'hDEAD_BEEF);
    idle();
    tick();

    // protected and out-of-range addresses: accepted, dropped, flagged
    for (int i = 0; i < N; i++) begin
      logic [AW-1:0] bad;
      bad = (i == 0) ? 8'd0 : (i == 1) ? 8'd1 : 8'd100;
      idle();
      set_req(i, 1'b1, bad, {$urandom, $urandom});
      tick();
      chk("prot_err", 64'(wr_err), 64'd1);
      chk("prot_we", 64'(rf_we), 64'd0);
      idle();
      tick();
      chk("prot_err_clear", 64'(wr_err), 64'd0);
    end
    all_valid_in_range();
    #1;
    chk("prot_ptr_advanced", 64'(req_ready), 64'b001);
    tick(); tick();

    // reset in the middle of init
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (40) tick();
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_we", 64'(rf_we), 64'd0);
    chk("midrst_done", 64'(init_done), 64'd0);
    chk("midrst_waddr", 64'(rf_waddr), 64'd0);
    tick();
    reset = 1'b0;
    run_init("midrst");

    // soft_init with requests pending
    repeat (4) begin
      all_valid_in_range();
      tick();
    end
    all_valid_in_range();
    soft_init = 1'b1;
    #1;
    chk("soft_no_grant", 64'(req_ready), 64'd0);
    tick();
    soft_init = 1'b0;
    chk("soft_done_low", 64'(init_done), 64'd0);
    chk("soft_we_low", 64'(rf_we), 64'd0);
    run_init("soft");

    // random traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        int r;
        logic [AW-1:0] a;
        r = $urandom_range(0, 9);
        if (r == 0)      a = AW'($urandom_range(0, 1));
        else if (r == 1) a = AW'($urandom_range(100, 255));
        else             a = AW'($urandom_range(2, NR - 1));
        set_req(i, ($urandom_range(0, 3) != 0), a, {$urandom, $urandom});
      end
      soft_init = ($urandom_range(0, 63) == 0);
      tick();
    end
    soft_init = 1'b0;
    idle();
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
